// File: rtl/useq_pkg.sv
// rtl/useq_pkg.sv - shared types and constants for the microsequencer
package useq_pkg;

    typedef enum logic [2:0] {
        SEQ    = 3'd0,
        FETCH  = 3'd1,
        DISP1  = 3'd2,
        DISP2  = 3'd3,
        JUMP   = 3'd4,
        BRANCH = 3'd5,
        CALL   = 3'd6,
        RET    = 3'd7
    } addr_ctl_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // first-level dispatch entry points
    localparam int D1_RTYPE  = 6;
    localparam int D1_ITYPE  = 8;
    localparam int D1_JAL    = 9;
    localparam int D1_BRANCH = 10;
    localparam int D1_MEM    = 2;
    localparam int D1_LUI    = 11;
    localparam int D1_AUIPC  = 12;
    localparam int D1_JALR   = 13;

    // second-level dispatch entry points (memory ops only)
    localparam int D2_LOAD   = 3;
    localparam int D2_STORE  = 5;

endpackage

// File: rtl/useq_dispatch_rom.sv
// rtl/useq_dispatch_rom.sv - opcode to micro-address dispatch table
module useq_dispatch_rom #(
    parameter int TABLE   = 1,
    parameter int UADDR_W = 5
) (
    input  logic [6:0]         op,
    output logic [UADDR_W-1:0] value,
    output logic               valid
);
    import useq_pkg::*;

    // decode the opcode; undefined opcodes report valid=0 and the caller traps
    always_comb begin
        value = '0;
        valid = 1'b1;
        if (TABLE == 1) begin
            case (op)
                OP_RTYPE:  value = UADDR_W'(D1_RTYPE);
                OP_ITYPE:  value = UADDR_W'(D1_ITYPE);
                OP_JAL:    value = UADDR_W'(D1_JAL);
                OP_BRANCH: value = UADDR_W'(D1_BRANCH);
                OP_LOAD:   value = UADDR_W'(D1_MEM);
                OP_STORE:  value = UADDR_W'(D1_MEM);
                OP_LUI:    value = UADDR_W'(D1_LUI);
                OP_AUIPC:  value = UADDR_W'(D1_AUIPC);
                OP_JALR:   value = UADDR_W'(D1_JALR);
                default:   valid = 1'b0;
            endcase
        end else begin
            case (op)
                OP_LOAD:   value = UADDR_W'(D2_LOAD);
                OP_STORE:  value = UADDR_W'(D2_STORE);
                default:   valid = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/microsequencer.sv
// rtl/microsequencer.sv - next-microaddress sequencer with return stack
module microsequencer #(
    parameter int UADDR_W     = 5,
    parameter int STACK_DEPTH = 4,
    parameter int FETCH_ADDR  = 0,
    parameter int TRAP_ADDR   = (1 << UADDR_W) - 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [6:0]         op,
    input  logic [2:0]         addr_ctl,
    input  logic [UADDR_W-1:0] target,
    input  logic               cond,
    output logic [UADDR_W-1:0] upc,
    output logic               illegal_op,
    output logic               stack_err
);
    import useq_pkg::*;

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [UADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [SP_W-1:0]    sp;

    addr_ctl_t          ctl;
    logic [UADDR_W-1:0] upc_inc;
    logic [UADDR_W-1:0] trap_a;
    logic [UADDR_W-1:0] fetch_a;
    logic [UADDR_W-1:0] d1_value;
    logic [UADDR_W-1:0] d2_value;
    logic               d1_valid;
    logic               d2_valid;
    logic               full;
    logic               empty;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   pop_idx;

    logic [UADDR_W-1:0] nxt;
    logic               push;
    logic               pop;
    logic               set_ill;
    logic               set_serr;

    assign ctl      = addr_ctl_t'(addr_ctl);
    assign upc_inc  = upc + UADDR_W'(1);
    assign trap_a   = UADDR_W'(TRAP_ADDR);
    assign fetch_a  = UADDR_W'(FETCH_ADDR);
    assign full     = (sp == SP_W'(STACK_DEPTH));
    assign empty    = (sp == '0);
    assign push_idx = IDX_W'(sp);
    assign pop_idx  = IDX_W'(sp - SP_W'(1));

    useq_dispatch_rom #(.TABLE(1), .UADDR_W(UADDR_W)) u_disp1 (
        .op    (op),
        .value (d1_value),
        .valid (d1_valid)
    );

    useq_dispatch_rom #(.TABLE(2), .UADDR_W(UADDR_W)) u_disp2 (
        .op    (op),
        .value (d2_value),
        .valid (d2_valid)
    );

    // select next micro-address and the stack/flag side effects it implies
    always_comb begin
        nxt      = upc_inc;
        push     = 1'b0;
        pop      = 1'b0;
        set_ill  = 1'b0;
        set_serr = 1'b0;
        case (ctl)
            SEQ:    nxt = upc_inc;
            FETCH:  nxt = fetch_a;
            DISP1: begin
                nxt     = d1_valid ? d1_value : trap_a;
                set_ill = ~d1_valid;
            end
            DISP2: begin
                nxt     = d2_valid ? d2_value : trap_a;
                set_ill = ~d2_valid;
            end
            JUMP:   nxt = target;
            BRANCH: nxt = cond ? target : upc_inc;
            CALL: begin
                if (full) begin
                    nxt      = trap_a;
                    set_serr = 1'b1;
                end else begin
                    nxt  = target;
                    push = 1'b1;
                end
            end
            RET: begin
                if (empty) begin
                    nxt      = trap_a;
                    set_serr = 1'b1;
                end else begin
                    nxt = stack_mem[pop_idx];
                    pop = 1'b1;
                end
            end
            default: nxt = upc_inc;
        endcase
    end

    // micro-PC, stack pointer and sticky fault flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upc        <= UADDR_W'(FETCH_ADDR);
            sp         <= '0;
            illegal_op <= 1'b0;
            stack_err  <= 1'b0;
        end else if (!stall) begin
            upc <= nxt;
            if (push)
                sp <= sp + SP_W'(1);
            else if (pop)
                sp <= sp - SP_W'(1);
            if (set_ill)
                illegal_op <= 1'b1;
            if (set_serr)
                stack_err <= 1'b1;
        end
    end

    // return-address storage; contents are meaningless once sp is reset
    always_ff @(posedge clk) begin
        if (!stall && push)
            stack_mem[push_idx] <= upc_inc;
    end

endmodule
